// File: rtl/logic_writeback_pkg.sv
// Shared sizing and types for the Game-of-Life writeback stage.
package logic_writeback_pkg;
   localparam int NUM_PE      = 1;
   localparam int WORD_SIZE   = 16;
   localparam int BOARD_WORDS = 19200;
   localparam int ADDR_W      = $clog2(BOARD_WORDS);

   typedef logic [ADDR_W-1:0]    addr_t;
   typedef logic [WORD_SIZE-1:0] data_t;

   typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/logic_writeback_if.sv
// Capture-side controls and memory write port of the writeback stage.
interface logic_writeback_if #(
   parameter int NUM_PE    = logic_writeback_pkg::NUM_PE,
   parameter int WORD_SIZE = logic_writeback_pkg::WORD_SIZE,
   parameter int AW        = logic_writeback_pkg::ADDR_W
);
   logic                 stall_in;
   logic                 start_in;
   logic [NUM_PE-1:0]    next_state_in;
   logic                 wr_en_out;
   logic [AW-1:0]        addr_w_out;
   logic [WORD_SIZE-1:0] data_w_out;
   logic                 done_out;

   modport slave (
      input  stall_in, start_in, next_state_in,
      output wr_en_out, addr_w_out, data_w_out, done_out
   );
   modport master (
      output stall_in, start_in, next_state_in,
      input  wr_en_out, addr_w_out, data_w_out, done_out
   );
endinterface

// File: rtl/logic_writeback.sv
// Packs NUM_PE next-state bits per cycle into words and writes them to the
// next-generation board memory; pulses done with the final word.
module logic_writeback #(
   parameter int NUM_PE      = logic_writeback_pkg::NUM_PE,
   parameter int WORD_SIZE   = logic_writeback_pkg::WORD_SIZE,
   parameter int BOARD_WORDS = logic_writeback_pkg::BOARD_WORDS
) (
   input logic               clk_in,
   input logic               rst_n_in,
   logic_writeback_if.slave  bus
);
   import logic_writeback_pkg::*;

   // WORD_SIZE must be a multiple of NUM_PE so a group never straddles words.
   localparam int AW = $clog2(BOARD_WORDS);
   localparam int CW = $clog2(WORD_SIZE + 1);

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt, cnt_nxt, base_cnt, cnt_sum;
   logic [WORD_SIZE-1:0] word, word_nxt, base_word, filled;
   logic [AW-1:0]        idx, idx_nxt, base_idx;
   logic                 wr_q, wr_nxt, done_q, done_nxt, cap;
   logic [AW-1:0]        addr_q, addr_nxt;
   logic [WORD_SIZE-1:0] data_q, data_nxt;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state  <= IDLE;
         cnt    <= '0;
         word   <= '0;
         idx    <= '0;
         wr_q   <= 1'b0;
         done_q <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         word   <= word_nxt;
         idx    <= idx_nxt;
         wr_q   <= wr_nxt;
         done_q <= done_nxt;
         addr_q <= addr_nxt;
         data_q <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      word_nxt  = word;
      idx_nxt   = idx;
      wr_nxt    = 1'b0;
      done_nxt  = 1'b0;
      addr_nxt  = addr_q;
      data_nxt  = data_q;
      base_cnt  = cnt;
      base_word = word;
      base_idx  = idx;

      // A restart discards any partial word; a write already registered
      // on the outputs is unaffected.
      if (bus.start_in) begin
         state_nxt = RUN;
         base_cnt  = '0;
         base_word = '0;
         base_idx  = '0;
         cnt_nxt   = '0;
         word_nxt  = '0;
         idx_nxt   = '0;
      end

      cap     = !bus.stall_in && (bus.start_in || state == RUN);
      filled  = base_word | (WORD_SIZE'(bus.next_state_in) << base_cnt);
      cnt_sum = base_cnt + CW'(NUM_PE);

      if (cap) begin
         if (cnt_sum == CW'(WORD_SIZE)) begin
            wr_nxt   = 1'b1;
            addr_nxt = base_idx;
            data_nxt = filled;
            cnt_nxt  = '0;
            word_nxt = '0;
            if (base_idx == AW'(BOARD_WORDS - 1)) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = base_idx + AW'(1);
            end
         end else begin
            cnt_nxt  = cnt_sum;
            word_nxt = filled;
         end
      end
   end

   assign bus.wr_en_out  = wr_q;
   assign bus.done_out   = done_q;
   assign bus.addr_w_out = addr_q;
   assign bus.data_w_out = data_q;
endmodule

// File: tb/tb_logic_writeback.sv
// Scoreboard bench: one single-bit DUT with a 4-word board and one 4-wide DUT
// with the default board size.
module tb_logic_writeback;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic_writeback_if #(.NUM_PE(1), .WORD_SIZE(16), .AW(2))  bus_a ();
   logic_writeback_if #(.NUM_PE(4), .WORD_SIZE(16), .AW(15)) bus_b ();

   logic_writeback #(.NUM_PE(1), .WORD_SIZE(16), .BOARD_WORDS(4)) dut_a (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus_a.slave));
   logic_writeback #(.NUM_PE(4), .WORD_SIZE(16), .BOARD_WORDS(19200)) dut_b (
      .clk_in(clk), .rst_n_in(rst_n), .bus(bus_b.slave));

   typedef struct {
      logic [14:0] addr;
      logic [15:0] data;
      logic        done;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t ea, eb;
   int checks = 0;
   int passed = 0;

   task automatic push_a(input logic [14:0] a, input logic [15:0] d, input logic dn);
      exp_t e;
      e.addr = a; e.data = d; e.done = dn;
      q_a.push_back(e);
   endtask

   task automatic push_b(input logic [14:0] a, input logic [15:0] d, input logic dn);
      exp_t e;
      e.addr = a; e.data = d; e.done = dn;
      q_b.push_back(e);
   endtask

   task automatic drive_a(input logic st, input logic sl, input logic b);
      bus_a.start_in      = st;
      bus_a.stall_in      = sl;
      bus_a.next_state_in = b;
      @(posedge clk); #1;
      bus_a.start_in = 1'b0;
      bus_a.stall_in = 1'b0;
   endtask

   task automatic drive_b(input logic st, input logic sl, input logic [3:0] n);
      bus_b.start_in      = st;
      bus_b.stall_in      = sl;
      bus_b.next_state_in = n;
      @(posedge clk); #1;
      bus_b.start_in = 1'b0;
      bus_b.stall_in = 1'b0;
   endtask

   task automatic send_word_a(input logic [15:0] w, input logic first_start);
      for (int i = 0; i < 16; i++) drive_a(first_start && (i == 0), 1'b0, w[i]);
   endtask

   task automatic check_zero(input string name, input logic wr, input logic dn,
                             input logic [14:0] a, input logic [15:0] d);
      checks++;
      if (!wr && !dn && a == '0 && d == '0) passed++;
      else $display("FAIL %s: wr=%0b done=%0b addr=%0h data=%0h, required all 0",
                    name, wr, dn, a, d);
   endtask

   always @(negedge clk) begin
      if (bus_a.wr_en_out) begin
         checks++;
         if (q_a.size() == 0) begin
            $display("FAIL a_unexpected_write: addr=%0h data=%0h, required no write",
                     bus_a.addr_w_out, bus_a.data_w_out);
         end else begin
            ea = q_a.pop_front();
            if (15'(bus_a.addr_w_out) == ea.addr && bus_a.data_w_out == ea.data &&
                bus_a.done_out == ea.done) passed++;
            else $display("FAIL a_write: addr=%0h data=%0h done=%0b, required addr=%0h data=%0h done=%0b",
                          bus_a.addr_w_out, bus_a.data_w_out, bus_a.done_out,
                          ea.addr, ea.data, ea.done);
         end
      end else if (bus_a.done_out) begin
         checks++;
         $display("FAIL a_stray_done: done=1 without write, required 0");
      end
   end

   always @(negedge clk) begin
      if (bus_b.wr_en_out) begin
         checks++;
         if (q_b.size() == 0) begin
            $display("FAIL b_unexpected_write: addr=%0h data=%0h, required no write",
                     bus_b.addr_w_out, bus_b.data_w_out);
         end else begin
            eb = q_b.pop_front();
            if (bus_b.addr_w_out == eb.addr && bus_b.data_w_out == eb.data &&
                bus_b.done_out == eb.done) passed++;
            else $display("FAIL b_write: addr=%0h data=%0h done=%0b, required addr=%0h data=%0h done=%0b",
                          bus_b.addr_w_out, bus_b.data_w_out, bus_b.done_out,
                          eb.addr, eb.data, eb.done);
         end
      end else if (bus_b.done_out) begin
         checks++;
         $display("FAIL b_stray_done: done=1 without write, required 0");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus_a.start_in = 1'b0; bus_a.stall_in = 1'b0; bus_a.next_state_in = '0;
      bus_b.start_in = 1'b0; bus_b.stall_in = 1'b0; bus_b.next_state_in = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_a", bus_a.wr_en_out, bus_a.done_out, 15'(bus_a.addr_w_out), bus_a.data_w_out);
      check_zero("reset_b", bus_b.wr_en_out, bus_b.done_out, bus_b.addr_w_out, bus_b.data_w_out);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Idle inputs before any start must be ignored.
      for (int i = 0; i < 4; i++) drive_a(1'b0, 1'b0, 1'b1);

      // Basic pack: 1 then 1,0,1,0,...
      push_a(15'd0, 16'hAAAB, 1'b0);
      drive_a(1'b1, 1'b0, 1'b1);
      for (int i = 1; i < 16; i++) drive_a(1'b0, 1'b0, logic'(i % 2));

      // Stall during second word: C3A5 LSB-first with two stalled cycles.
      push_a(15'd1, 16'hC3A5, 1'b0);
      drive_a(0, 0, 1); drive_a(0, 0, 0); drive_a(0, 0, 1); drive_a(0, 0, 0);
      drive_a(0, 1, 1); drive_a(0, 1, 0);
      drive_a(0, 0, 0); drive_a(0, 0, 1); drive_a(0, 0, 0); drive_a(0, 0, 1);
      drive_a(0, 0, 1); drive_a(0, 0, 1); drive_a(0, 0, 0); drive_a(0, 0, 0);
      drive_a(0, 0, 0); drive_a(0, 0, 0); drive_a(0, 0, 1); drive_a(0, 0, 1);

      // Async reset mid-run clears the outputs at once.
      for (int i = 0; i < 5; i++) drive_a(1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #2;
      check_zero("async_reset_a", bus_a.wr_en_out, bus_a.done_out, 15'(bus_a.addr_w_out), bus_a.data_w_out);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_word_a(16'hFFFF, 1'b0);

      // Restart after 5 captures: partial word dropped, address back to 0.
      for (int i = 0; i < 5; i++) drive_a(i == 0, 1'b0, 1'b1);
      push_a(15'd0, 16'h0F0F, 1'b0);
      send_word_a(16'h0F0F, 1'b1);

      // Full 4-word board, done with the last write, then ignored input.
      push_a(15'd0, 16'h0001, 1'b0);
      push_a(15'd1, 16'h8000, 1'b0);
      push_a(15'd2, 16'hFFFF, 1'b0);
      push_a(15'd3, 16'h5555, 1'b1);
      send_word_a(16'h0001, 1'b1);
      send_word_a(16'h8000, 1'b0);
      send_word_a(16'hFFFF, 1'b0);
      send_word_a(16'h5555, 1'b0);
      send_word_a(16'h1234, 1'b0);

      // Four cells per cycle.
      push_b(15'd0, 16'h4321, 1'b0);
      drive_b(1, 0, 4'h1); drive_b(0, 0, 4'h2); drive_b(0, 0, 4'h3); drive_b(0, 0, 4'h4);
      push_b(15'd1, 16'h5A0F, 1'b0);
      drive_b(0, 0, 4'hF); drive_b(0, 1, 4'h6); drive_b(0, 0, 4'h0);
      drive_b(0, 0, 4'hA); drive_b(0, 0, 4'h5);
      // Stalled start restarts without capturing; start beside a pending write.
      push_b(15'd0, 16'hBA98, 1'b0);
      push_b(15'd0, 16'h4321, 1'b0);
      drive_b(1, 1, 4'h7);
      drive_b(0, 0, 4'h8); drive_b(0, 0, 4'h9); drive_b(0, 0, 4'hA); drive_b(0, 0, 4'hB);
      drive_b(1, 0, 4'h1); drive_b(0, 0, 4'h2); drive_b(0, 0, 4'h3); drive_b(0, 0, 4'h4);

      for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q_a.size() == 0) passed++;
      else $display("FAIL a_pending: %0d writes outstanding, required 0", q_a.size());
      checks++;
      if (q_b.size() == 0) passed++;
      else $display("FAIL b_pending: %0d writes outstanding, required 0", q_b.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
